// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
//   Walks every output pixel of every output channel and emits one convolution
//   tap per cycle (image address plus MAC framing flags) under valid/ready.
//   Loop order, innermost first: kc, kr, ic, ocol, orow, oc.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start           pulse; begins a full pass when idle
//   busy            high from accepted start until the final handshake
//   done            one-cycle pulse after the final handshake
//   out_valid       tap fields valid
//   out_ready       MAC accepts the current tap
//   tap_addr        ic*IMG_H*IMG_W + r*IMG_W + c, or 0 for a padding tap
//   tap_pad         tap lies in the zero padding
//   tap_oc          output channel of the tap
//   tap_first       first tap of an output pixel (clear accumulator)
//   tap_last        last tap of an output pixel (write result)
//   stall_cnt       cycles with out_valid && !out_ready, saturating; present
//                   only when CONV_SCHED_STALL_CNT_EN is defined
module conv_window_scheduler #(
    parameter int IN_CH  = 2,
    parameter int OUT_CH = 1,
    parameter int IMG_H  = 4,
    parameter int IMG_W  = 4,
    parameter int K_H    = 3,
    parameter int K_W    = 3,
    parameter int STRIDE = 1,
    parameter int PAD    = 0,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        tap_addr,
    output logic                     tap_pad,
    output logic [$clog2(OUT_CH):0]  tap_oc,
    output logic                     tap_first,
    output logic                     tap_last
`ifdef CONV_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int OUT_H = (IMG_H + 2*PAD - K_H) / STRIDE + 1;
    localparam int OUT_W = (IMG_W + 2*PAD - K_W) / STRIDE + 1;

    localparam int KCW = $clog2(K_W + 1);
    localparam int KRW = $clog2(K_H + 1);
    localparam int ICW = $clog2(IN_CH + 1);
    localparam int OXW = $clog2(OUT_W + 1);
    localparam int OYW = $clog2(OUT_H + 1);
    localparam int OCW = $clog2(OUT_CH) + 1;
    localparam int RW  = $clog2(IMG_H + PAD) + 2;
    localparam int CW  = $clog2(IMG_W + PAD) + 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]     state;
    logic [KCW-1:0] kc,   n_kc;
    logic [KRW-1:0] kr,   n_kr;
    logic [ICW-1:0] ic,   n_ic;
    logic [OXW-1:0] ocol, n_ocol;
    logic [OYW-1:0] orow, n_orow;
    logic [OCW-1:0] oc,   n_oc;

    logic start_acc, adv, final_tap;
    logic c0, c1, c2, c3, c4;
    logic signed [RW-1:0] r;
    logic signed [CW-1:0] c;
    logic [ADDR_W-1:0] n_addr;
    logic n_pad, n_first, n_last;

    assign start_acc = (state == IDLE) && start;
    assign adv       = (state == RUN) && out_valid && out_ready;

    // Carry chain: each stage advances only when every inner loop wraps.
    always_comb begin
        c0 = (kc   == KCW'(K_W - 1));
        c1 = c0 && (kr   == KRW'(K_H - 1));
        c2 = c1 && (ic   == ICW'(IN_CH - 1));
        c3 = c2 && (ocol == OXW'(OUT_W - 1));
        c4 = c3 && (orow == OYW'(OUT_H - 1));
        final_tap = c4 && (oc == OCW'(OUT_CH - 1));

        n_kc   = kc;
        n_kr   = kr;
        n_ic   = ic;
        n_ocol = ocol;
        n_orow = orow;
        n_oc   = oc;
        if (start_acc) begin
            n_kc   = '0;
            n_kr   = '0;
            n_ic   = '0;
            n_ocol = '0;
            n_orow = '0;
            n_oc   = '0;
        end else if (adv) begin
            n_kc = c0 ? '0 : kc + 1'b1;
            if (c0) n_kr   = (kr   == KRW'(K_H - 1))   ? '0 : kr + 1'b1;
            if (c1) n_ic   = (ic   == ICW'(IN_CH - 1)) ? '0 : ic + 1'b1;
            if (c2) n_ocol = (ocol == OXW'(OUT_W - 1)) ? '0 : ocol + 1'b1;
            if (c3) n_orow = (orow == OYW'(OUT_H - 1)) ? '0 : orow + 1'b1;
            if (c4) n_oc   = (oc   == OCW'(OUT_CH - 1)) ? '0 : oc + 1'b1;
        end
    end

    // Tap fields are derived from the next counter values so the outputs can be
    // registered without adding a cycle of latency.
    always_comb begin
        r       = RW'(int'(n_orow) * STRIDE + int'(n_kr) - PAD);
        c       = CW'(int'(n_ocol) * STRIDE + int'(n_kc) - PAD);
        n_pad   = (int'(r) < 0) || (int'(r) >= IMG_H) || (int'(c) < 0) || (int'(c) >= IMG_W);
        n_addr  = n_pad ? '0
                        : ADDR_W'(int'(n_ic) * (IMG_H * IMG_W) + int'(r) * IMG_W + int'(c));
        n_first = (n_ic == '0) && (n_kr == '0) && (n_kc == '0);
        n_last  = (n_ic == ICW'(IN_CH - 1)) && (n_kr == KRW'(K_H - 1)) && (n_kc == KCW'(K_W - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            kc        <= '0;
            kr        <= '0;
            ic        <= '0;
            ocol      <= '0;
            orow      <= '0;
            oc        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            tap_addr  <= '0;
            tap_pad   <= 1'b0;
            tap_oc    <= '0;
            tap_first <= 1'b0;
            tap_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            kc   <= n_kc;
            kr   <= n_kr;
            ic   <= n_ic;
            ocol <= n_ocol;
            orow <= n_orow;
            oc   <= n_oc;
            if (start_acc || (adv && !final_tap)) begin
                tap_addr  <= n_addr;
                tap_pad   <= n_pad;
                tap_oc    <= n_oc;
                tap_first <= n_first;
                tap_last  <= n_last;
            end
            if (start_acc) begin
                state     <= RUN;
                busy      <= 1'b1;
                out_valid <= 1'b1;
            end else if (adv && final_tap) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

`ifdef CONV_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
